logic_seq_exec: RTL and testbench

- Sequenced command front-end for the ALU logic path.
- Accepts a logic command (opcode plus two operands) over a valid/ready handshake.
- Decodes the opcode into the one-hot controls and/or/xor plus an inv modifier, then evaluates the operation SLICE bits per cycle, LSB slice first, using a narrow internal logic slice.
- Returns the full-width result with zero and error flags over a second valid/ready handshake. Sits between the ALU controller and the result bus.

---
 rtl/logic_seq_exec.sv | 129 ++++++++++++
 tb/tb_logic_seq_exec.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_seq_exec.sv
// Sequenced logic-op front-end: accepts an opcode and two operands, evaluates
// the operation SLICE bits per cycle (LSB slice first) and returns the result.
module logic_seq_exec #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_c,
   output logic             res_zero,
   output logic             res_err,
   output logic             busy
);

   localparam int unsigned NSL = WIDTH / SLICE;
   localparam int unsigned CW  = $clog2(NSL) + 1;

   if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("logic_seq_exec: SLICE must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
   logic [CW-1:0]    cnt;
   logic [3:0]       ctrl;          // {and, or, xor, inv}
   logic [SLICE-1:0] slice_a, slice_b, slice_res;
   logic             op_ok, last;

   function automatic logic [3:0] decode(input logic [2:0] op);
      case (op)
         3'd0:    return 4'b1000;
         3'd1:    return 4'b0100;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0001;
         3'd4:    return 4'b1001;
         3'd5:    return 4'b0101;
         3'd6:    return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   assign op_ok   = (cmd_op != 3'd7);
   assign last    = (cnt == CW'(NSL - 1));
   assign slice_a = a_sh[SLICE-1:0];
   assign slice_b = b_sh[SLICE-1:0];

   // Narrow logic slice plus accumulator shift-in from the MSB side
   always_comb begin
      slice_res = '0;
      if (ctrl[3]) slice_res = slice_res | (slice_a & slice_b);
      if (ctrl[2]) slice_res = slice_res | (slice_a | slice_b);
      if (ctrl[1]) slice_res = slice_res | (slice_a ^ slice_b);
      slice_res = slice_res ^ {SLICE{ctrl[0]}};
      acc_nxt   = WIDTH'({slice_res, acc} >> SLICE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (cmd_valid) state_n = op_ok ? EXEC : DONE;
         EXEC:    if (last) state_n = DONE;
         DONE:    if (res_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered handshake/result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         res_c     <= '0;
         res_zero  <= 1'b0;
         res_err   <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         acc       <= '0;
         cnt       <= '0;
         ctrl      <= '0;
      end else begin
         cmd_ready <= (state_n == IDLE);
         res_valid <= (state_n == DONE);
         busy      <= (state_n != IDLE);
         case (state)
            IDLE: if (cmd_valid) begin
               a_sh <= cmd_a;
               b_sh <= cmd_b;
               ctrl <= decode(cmd_op);
               cnt  <= '0;
               acc  <= '0;
               if (!op_ok) begin
                  res_c    <= '0;
                  res_zero <= 1'b1;
                  res_err  <= 1'b1;
               end
            end
            EXEC: begin
               acc  <= acc_nxt;
               a_sh <= a_sh >> SLICE;
               b_sh <= b_sh >> SLICE;
               if (last) begin
                  res_c    <= acc_nxt;
                  res_zero <= (acc_nxt == '0);
                  res_err  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_seq_exec.sv
// Scoreboard bench for logic_seq_exec: directed and random commands on a SLICE=2
// instance plus random sweeps on SLICE=1,4,8 instances against a behavioural model.
module tb_logic_seq_exec;

   localparam int unsigned W   = 8;
   localparam int unsigned S   = 2;
   localparam int          LAT = W / S + 1;

   typedef struct {
      logic [7:0] res;
      logic       zero;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_a = 8'h00;
   logic [7:0] cmd_b = 8'h00;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [7:0] res_c;
   logic       res_zero, res_err, busy;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rise = 0;
   bit   pv = 1'b0;
   bit   rr_rand = 1'b0;
   bit   rr_hold = 1'b1;
   bit   sweep_go = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return 8'hFF;
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         3'd6:    return ~(a ^ b);
         default: return 8'h00;
      endcase
   endfunction

   function automatic exp_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input int acc, input int lat_legal);
      exp_t e;
      e.res  = model(op, a, b);
      e.zero = (e.res == 8'h00);
      e.err  = (op == 3'd7);
      e.lat  = (op == 3'd7) ? 1 : lat_legal;
      e.acc  = acc;
      return e;
   endfunction

   logic_seq_exec #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c),
      .res_zero(res_zero), .res_err(res_err), .busy(busy)
   );

   // res_ready changes just after the active edge
   initial forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_hold;
   end

   // Monitor: result must match queue head and hold steady under backpressure
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (res_valid && !pv) rise = cyc;
         if (res_valid) begin
            chk("cmd_ready_in_done", int'(cmd_ready), 0);
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               chk("res_c", int'(res_c), int'(q[0].res));
               if (res_ready) begin
                  chk("res_zero", int'(res_zero), int'(q[0].zero));
                  chk("res_err", int'(res_err), int'(q[0].err));
                  chk("latency", rise - q[0].acc + 1, q[0].lat);
                  void'(q.pop_front());
               end
            end
         end
         pv = res_valid;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit push);
      int t;
      t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) chk("accept_timeout", 0, 1);
      else if (push) q.push_back(mk(op, a, b, cyc + 1, LAT));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_res_valid"}, int'(res_valid), 0);
      chk({tag, "_res_c"}, int'(res_c), 0);
      chk({tag, "_res_zero"}, int'(res_zero), 0);
      chk({tag, "_res_err"}, int'(res_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   // Extra instances with other slice widths, each with its own driver and scoreboard
   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int unsigned SL = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
      localparam int          SLAT = W / SL + 1;
      logic       cv, rdy, vld, rr, zr, er, bz;
      logic [2:0] op;
      logic [7:0] a, b, rc;
      exp_t       sq[$];
      int         srise;
      bit         spv;
      bit         done;

      logic_seq_exec #(.WIDTH(W), .SLICE(SL)) u_sw (
         .clk(clk), .rst_n(rst_n),
         .cmd_valid(cv), .cmd_ready(rdy), .cmd_op(op), .cmd_a(a), .cmd_b(b),
         .res_valid(vld), .res_ready(rr), .res_c(rc),
         .res_zero(zr), .res_err(er), .busy(bz)
      );

      initial begin
         int t;
         cv = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; done = 1'b0;
         wait (sweep_go);
         for (int k = 0; k < 30; k++) begin
            t = 0;
            @(negedge clk);
            cv = 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            while (!rdy && t < 100) begin
               @(negedge clk);
               t++;
            end
            if (!rdy) chk("sweep_accept_timeout", 0, 1);
            else sq.push_back(mk(op, a, b, cyc + 1, SLAT));
            @(posedge clk);
            #1 cv = 1'b0;
         end
         t = 0;
         while (sq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (sq.size() != 0) chk("sweep_drain_timeout", sq.size(), 0);
         done = 1'b1;
      end

      initial begin
         rr = 1'b1;
         forever begin
            @(posedge clk);
            #1 rr = ($urandom_range(0, 2) != 0);
         end
      end

      initial begin
         spv = 1'b0;
         srise = 0;
      end

      always @(negedge clk) begin
         if (rst_n) begin
            if (vld && !spv) srise = cyc;
            if (vld) begin
               if (sq.size() == 0) begin
                  chk("sweep_unexpected_result", 1, 0);
               end else if (rr) begin
                  chk("sweep_res_c", int'(rc), int'(sq[0].res));
                  chk("sweep_res_zero", int'(zr), int'(sq[0].zero));
                  chk("sweep_res_err", int'(er), int'(sq[0].err));
                  chk("sweep_latency", srise - sq[0].acc + 1, sq[0].lat);
                  void'(sq.pop_front());
               end
            end
            spv = vld;
         end
      end
   end

   initial begin
      int t;
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with res_ready held high
      issue(3'd0, 8'hF0, 8'h3C, 1'b1);
      drain();
      issue(3'd4, 8'hFF, 8'hFF, 1'b1);
      issue(3'd6, 8'hA5, 8'h5A, 1'b1);
      issue(3'd1, 8'h81, 8'h18, 1'b1);
      issue(3'd3, 8'h12, 8'h34, 1'b1);
      issue(3'd7, 8'h55, 8'hAA, 1'b1);
      issue(3'd2, 8'h33, 8'h33, 1'b1);
      drain();

      // Backpressure: XOR result held for 6 cycles while a second command waits
      rr_hold = 1'b0;
      repeat (2) @(posedge clk);
      issue(3'd2, 8'h0F, 8'hFF, 1'b1);
      fork
         issue(3'd1, 8'h81, 8'h18, 1'b1);
         begin
            t = 0;
            while (!res_valid && t < 20) begin
               @(negedge clk);
               t++;
            end
            chk("bp_res_valid_seen", int'(res_valid), 1);
            repeat (6) @(negedge clk);
            rr_hold = 1'b1;
         end
      join
      drain();

      // Asynchronous reset in the middle of EXEC
      issue(3'd0, 8'hFF, 8'h0F, 1'b0);
      @(posedge clk);
      #2 chk("busy_in_exec", int'(busy), 1);
      rst_n = 1'b0;
      #1 check_reset_outputs("mid_exec_reset");
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd0, 8'h0F, 8'h0F, 1'b1);
      drain();

      // Random commands with random backpressure
      rr_rand = 1'b1;
      for (int k = 0; k < 60; k++)
         issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
      drain();
      rr_rand = 1'b0;

      // Slice-width sweep
      sweep_go = 1'b1;
      t = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) chk("sweep_timeout", 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
